bcd2bin_serial: RTL

- Serial BCD-to-binary converter, the decoder counterpart of the bin2bcd_serial encoder used by the score path.
- Converts a packed BCD number, e.g. a 3-digit value 000–999 from digit-entry or high-score logic, back to plain binary for arithmetic and compare logic.
- Uses reverse double-dabble: one binary bit is resolved per clock, so conversion takes BINARY_BITS cycles.
- Has a start/busy/done handshake and flags invalid BCD digits.

---
 rtl/bcd2bin_serial.sv | 117 +++++++++++
 1 files changed

// File: rtl/bcd2bin_serial.sv
// Serial BCD-to-binary converter using reverse double-dabble: one binary bit
// is resolved per clock, with a start/busy/done handshake and invalid-digit flag.
module bcd2bin_serial #(
  parameter int BINARY_BITS = 10,
  parameter int BCD_DIGITS  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4*BCD_DIGITS-1:0] bcd_in,
  output logic [BINARY_BITS-1:0]  binary_out,
  output logic                    busy,
  output logic                    done,
  output logic                    bcd_err
);

  localparam int BCD_W  = 4 * BCD_DIGITS;
  localparam int WORK_W = BCD_W + BINARY_BITS;
  localparam int CNT_W  = $clog2(BINARY_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BINARY_BITS - 1);

  // REJECT spends one cycle so an invalid request reports done on the edge
  // after acceptance without entering SHIFT.
  typedef enum logic [1:0] {IDLE, SHIFT, REJECT, DONE} state_t;

  state_t                   state, state_next;
  logic [WORK_W-1:0]        work, work_next, work_adj;
  logic [CNT_W-1:0]         cnt, cnt_next;
  logic [BINARY_BITS-1:0]   bin_next;
  logic                     err_next, busy_next, done_next;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (v[4*d +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which is what would otherwise infer a latch.
    state_next = state;
    work_next  = work;
    cnt_next   = cnt;
    bin_next   = binary_out;
    err_next   = bcd_err;
    busy_next  = 1'b0;
    done_next  = 1'b0;

    // Shift right, then pull each BCD digit that now reads >= 8 back by 3.
    work_adj = {1'b0, work[WORK_W-1:1]};
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (work_adj[BINARY_BITS + 4*d +: 4] >= 4'd8)
        work_adj[BINARY_BITS + 4*d +: 4] = work_adj[BINARY_BITS + 4*d +: 4] - 4'd3;
    end

    case (state)
      IDLE: begin
        if (start) begin
          if (has_bad_digit(bcd_in)) begin
            state_next = REJECT;
          end else begin
            state_next = SHIFT;
            work_next  = {bcd_in, {BINARY_BITS{1'b0}}};
            cnt_next   = '0;
            busy_next  = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_next = work_adj;
        cnt_next  = cnt + 1'b1;
        if (cnt == LAST_ITER) begin
          state_next = DONE;
          done_next  = 1'b1;
          bin_next   = work_adj[BINARY_BITS-1:0];
          err_next   = 1'b0;
        end else begin
          busy_next = 1'b1;
        end
      end
      REJECT: begin
        state_next = DONE;
        done_next  = 1'b1;
        bin_next   = '0;
        err_next   = 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      work       <= '0;
      cnt        <= '0;
      binary_out <= '0;
      bcd_err    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      work       <= work_next;
      cnt        <= cnt_next;
      binary_out <= bin_next;
      bcd_err    <= err_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

endmodule
